// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM request arbiter: captured request record,
// arbiter FSM states and the round-robin grant helper.
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_BITS = 22;
    localparam int SDRAM_DATA_BITS = 16;
    localparam int MAX_CLIENTS     = 4;

    typedef struct packed {
        logic                       we;
        logic [SDRAM_ADDR_BITS-1:0] address;
        logic [SDRAM_DATA_BITS-1:0] data_write;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // First pending client strictly after last_grant, wrapping over n
    // clients. Returns last_grant when nothing is pending.
    function automatic logic [1:0] rr_next(
        input logic [3:0] pending,
        input logic [1:0] last_grant,
        input int         n
    );
        logic [1:0] grant;
        logic       found;
        grant = last_grant;
        found = 1'b0;
        for (int k = 1; k <= MAX_CLIENTS; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % n;
            if (!found && k <= n && pending[idx[1:0]]) begin
                grant = idx[1:0];
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/sdram_req_latch.sv
// Per-client request holder: pending flag plus captured request fields.
// Ports: clk, rst_n, set/set_req (new pulse), consume (grant), pending, req.
module sdram_req_latch
    import sdram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  req_t set_req,
    input  logic consume,
    output logic pending,
    output req_t req
);

    logic pending_q, pending_d;
    req_t req_q, req_d;

    // A new pulse arriving with the consume wins: the request stays
    // pending and carries the newer fields.
    always_comb begin
        pending_d = set | (pending_q & ~consume);
        req_d     = set ? set_req : req_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            req_q     <= '0;
        end else begin
            pending_q <= pending_d;
            req_q     <= req_d;
        end
    end

    assign pending = pending_q;
    assign req     = req_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin merge of NUM_CLIENTS pulse request buses onto one SDRAM
// controller port, with per-client read-data holding and ack pulses.
// Ports: c_* client side (req/we/address/data in, data_read/ack out),
// mem_* controller side, timeout_err sticky watchdog flag.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = 2,
    parameter int ADDR_BITS      = SDRAM_ADDR_BITS,
    parameter int DATA_BITS      = SDRAM_DATA_BITS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CLIENTS-1:0]         c_req,
    input  logic [NUM_CLIENTS-1:0]         c_we,
    input  logic [NUM_CLIENTS*ADDR_BITS-1:0] c_address,
    input  logic [NUM_CLIENTS*DATA_BITS-1:0] c_data_write,
    output logic [NUM_CLIENTS*DATA_BITS-1:0] c_data_read,
    output logic [NUM_CLIENTS-1:0]         c_ack,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_BITS-1:0]           mem_address,
    output logic [DATA_BITS-1:0]           mem_data_write,
    input  logic [DATA_BITS-1:0]           mem_data_read,
    input  logic                           mem_ack,
    output logic                           timeout_err
);

    localparam int GW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [NUM_CLIENTS-1:0] pending;
    logic [NUM_CLIENTS-1:0] consume;
    req_t                   lreq [NUM_CLIENTS];

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_latch
        req_t set_req;
        assign set_req = {
            c_we[gi],
            SDRAM_ADDR_BITS'(c_address[gi*ADDR_BITS +: ADDR_BITS]),
            SDRAM_DATA_BITS'(c_data_write[gi*DATA_BITS +: DATA_BITS])
        };
        sdram_req_latch u_latch (
            .clk     (clk),
            .rst_n   (rst_n),
            .set     (c_req[gi]),
            .set_req (set_req),
            .consume (consume[gi]),
            .pending (pending[gi]),
            .req     (lreq[gi])
        );
    end

    state_t                         state_q, state_d;
    logic [GW-1:0]                  grant_q, grant_d;
    logic [GW-1:0]                  grant_sel;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           mem_req_q, mem_req_d;
    logic                           mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]           mem_address_q, mem_address_d;
    logic [DATA_BITS-1:0]           mem_data_write_q, mem_data_write_d;
    logic [NUM_CLIENTS-1:0]         c_ack_q, c_ack_d;
    logic [NUM_CLIENTS*DATA_BITS-1:0] c_data_read_q, c_data_read_d;
    logic                           timeout_err_q, timeout_err_d;

    assign grant_sel = GW'(rr_next(4'(pending), 2'(grant_q), NUM_CLIENTS));

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        cnt_d            = cnt_q;
        mem_req_d        = 1'b0;
        mem_we_d         = mem_we_q;
        mem_address_d    = mem_address_q;
        mem_data_write_d = mem_data_write_q;
        c_ack_d          = '0;
        c_data_read_d    = c_data_read_q;
        timeout_err_d    = timeout_err_q;
        consume          = '0;
        unique case (state_q)
            IDLE: begin
                // Fields move into the output registers at the grant,
                // so the latch is freed here rather than a cycle later.
                if (|pending) begin
                    grant_d            = grant_sel;
                    consume[grant_sel] = 1'b1;
                    mem_req_d          = 1'b1;
                    mem_we_d           = lreq[grant_sel].we;
                    mem_address_d      = ADDR_BITS'(lreq[grant_sel].address);
                    mem_data_write_d   = DATA_BITS'(lreq[grant_sel].data_write);
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_ack) begin
                    c_ack_d[grant_q] = 1'b1;
                    if (!mem_we_q) begin
                        c_data_read_d[grant_q*DATA_BITS +: DATA_BITS] =
                            mem_data_read;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d    = 1'b1;
                    c_ack_d[grant_q] = 1'b1;
                    state_d          = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            grant_q          <= GW'(NUM_CLIENTS - 1);
            cnt_q            <= '0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_address_q    <= '0;
            mem_data_write_q <= '0;
            c_ack_q          <= '0;
            c_data_read_q    <= '0;
            timeout_err_q    <= 1'b0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            cnt_q            <= cnt_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_address_q    <= mem_address_d;
            mem_data_write_q <= mem_data_write_d;
            c_ack_q          <= c_ack_d;
            c_data_read_q    <= c_data_read_d;
            timeout_err_q    <= timeout_err_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_address    = mem_address_q;
    assign mem_data_write = mem_data_write_q;
    assign c_ack          = c_ack_q;
    assign c_data_read    = c_data_read_q;
    assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: table of single transactions
// plus hand sequences, with a mem-side scoreboard and controller model.
module tb_sdram_arbiter;

    localparam int NC = 2;
    localparam int AW = 22;
    localparam int DW = 16;
    localparam int T  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NC-1:0]     c_req;
    logic [NC-1:0]     c_we;
    logic [NC*AW-1:0]  c_address;
    logic [NC*DW-1:0]  c_data_write;
    logic [NC*DW-1:0]  c_data_read;
    logic [NC-1:0]     c_ack;
    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data_write;
    logic [DW-1:0]     mem_data_read = '0;
    logic              mem_ack = 1'b0;
    logic              timeout_err;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .NUM_CLIENTS    (NC),
        .ADDR_BITS      (AW),
        .DATA_BITS      (DW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .c_req          (c_req),
        .c_we           (c_we),
        .c_address      (c_address),
        .c_data_write   (c_data_write),
        .c_data_read    (c_data_read),
        .c_ack          (c_ack),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read),
        .mem_ack        (mem_ack),
        .timeout_err    (timeout_err)
    );

    // dly > 0: ack dly cycles after mem_req; dly <= 0: watchdog expected
    // (0 = ack in the mem_req cycle, which must be ignored; -1 = never).
    typedef struct {
        int            cl;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            dly;
        bit            lat;
        int            req_cyc;
    } rec_t;

    typedef struct {
        int            cl;
        bit            we;
        logic [DW-1:0] rdata;
        int            cyc;
        bit            to;
    } ack_t;

    rec_t          exp_mem [$];
    ack_t          exp_ack [$];
    int            vectors    = 0;
    int            miscompares = 0;
    int            cyc        = 0;
    int            nmem       = 0;
    int            ack_at     = -1;
    logic [DW-1:0] ack_data   = '0;
    logic [DW-1:0] rd_model [NC];
    bit            te_model   = 1'b0;
    rec_t          tbl [7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic rec_t mk(int cl, bit we, logic [AW-1:0] addr,
                                logic [DW-1:0] wd, logic [DW-1:0] rd,
                                int dly, bit lat);
        rec_t r;
        r.cl = cl; r.we = we; r.addr = addr; r.wdata = wd;
        r.rdata = rd; r.dly = dly; r.lat = lat; r.req_cyc = 0;
        return r;
    endfunction

    // Controller model and scoreboard, sampled away from the rising edge.
    always @(negedge clk) begin
        rec_t r;
        ack_t e;
        if (rst_n && mem_req) begin
            nmem++;
            if (exp_mem.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_mem_req: got addr %0h expected none",
                         mem_address);
            end else begin
                r = exp_mem.pop_front();
                chk("mem_address", 64'(mem_address), 64'(r.addr));
                chk("mem_we", 64'(mem_we), 64'(r.we));
                if (r.we) chk("mem_data_write", 64'(mem_data_write), 64'(r.wdata));
                if (r.lat) chk("mem_req_cycle", 64'(cyc), 64'(r.req_cyc + 2));
                ack_at   = (r.dly >= 0) ? cyc + r.dly : -1;
                ack_data = r.rdata;
                e.cl     = r.cl;
                e.we     = r.we;
                e.rdata  = r.rdata;
                e.to     = (r.dly <= 0);
                e.cyc    = e.to ? cyc + T + 1 : cyc + r.dly + 1;
                exp_ack.push_back(e);
            end
        end
        mem_ack       = (ack_at >= 0) && (cyc == ack_at);
        mem_data_read = mem_ack ? ack_data : 16'hDEAD;
        if (mem_ack) ack_at = -1;
        for (int i = 0; i < NC; i++) begin
            if (rst_n && c_ack[i]) begin
                if (exp_ack.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_c_ack: got client %0d expected none", i);
                end else begin
                    e = exp_ack.pop_front();
                    chk("ack_client", 64'(i), 64'(e.cl));
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.to) te_model = 1'b1;
                    else if (!e.we) rd_model[e.cl] = e.rdata;
                    for (int j = 0; j < NC; j++)
                        chk("c_data_read", 64'(c_data_read[j*DW +: DW]),
                            64'(rd_model[j]));
                    chk("timeout_err", 64'(timeout_err), 64'(te_model));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        c_req        = '0;
        c_we         = 2'($urandom());
        c_address    = 44'({$urandom(), $urandom()});
        c_data_write = $urandom();
    endtask

    task automatic put(input rec_t r, input bit push);
        r.req_cyc                 = cyc;
        c_req[r.cl]               = 1'b1;
        c_we[r.cl]                = r.we;
        c_address[r.cl*AW +: AW]  = r.addr;
        c_data_write[r.cl*DW +: DW] = r.wdata;
        if (push) exp_mem.push_back(r);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 2000; i++) begin
            if (exp_mem.size() == 0 && exp_ack.size() == 0) break;
            tick();
        end
        if (i == 2000) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: got %0d outstanding expected 0",
                     exp_mem.size() + exp_ack.size());
        end
    endtask

    task automatic clear_model();
        exp_mem.delete();
        exp_ack.delete();
        ack_at   = -1;
        te_model = 1'b0;
        for (int i = 0; i < NC; i++) rd_model[i] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        chk({tag, "_mem_address"}, 64'(mem_address), 64'(0));
        chk({tag, "_mem_data_write"}, 64'(mem_data_write), 64'(0));
        chk({tag, "_c_ack"}, 64'(c_ack), 64'(0));
        chk({tag, "_c_data_read"}, 64'(c_data_read), 64'(0));
        chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    endtask

    initial begin
        int n0;
        int issued;
        tbl[0] = mk(0, 1'b0, 22'h00123,  16'h0000, 16'hBEEF, 5, 1'b1);
        tbl[1] = mk(1, 1'b0, 22'h2AAAA,  16'h0000, 16'h1357, 1, 1'b1);
        tbl[2] = mk(0, 1'b1, 22'h00001,  16'hA5A5, 16'h0000, 2, 1'b1);
        tbl[3] = mk(1, 1'b1, 22'h3FFFFF, 16'hFFFF, 16'h0000, 7, 1'b1);
        tbl[4] = mk(0, 1'b0, 22'h00000,  16'h0000, 16'hFFFF, 3, 1'b1);
        tbl[5] = mk(1, 1'b0, 22'h155555, 16'h0000, 16'h8001, 0, 1'b1);
        tbl[6] = mk(0, 1'b0, 22'h2BEEF,  16'h0000, 16'h4242, 2, 1'b1);

        rst_n        = 1'b0;
        c_req        = '0;
        c_we         = '0;
        c_address    = '0;
        c_data_write = '0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            put(tbl[i], 1'b1);
            tick();
            wait_done();
        end

        // Simultaneous requests straight after reset: client 0 first.
        do_reset();
        n0 = nmem;
        put(mk(0, 1'b0, 22'h00AAA, 16'h0, 16'h1111, 3, 1'b1), 1'b1);
        put(mk(1, 1'b0, 22'h00BBB, 16'h0, 16'h2222, 2, 1'b0), 1'b1);
        tick();
        wait_done();
        chk("simul_mem_reqs", 64'(nmem - n0), 64'(2));

        // Both clients re-request on each ack: strict alternation.
        n0 = nmem;
        issued = 2;
        put(mk(0, 1'b0, AW'(32'h100), 16'h0, 16'h0A00, 2, 1'b0), 1'b1);
        put(mk(1, 1'b0, AW'(32'h201), 16'h0, 16'h0B01, 3, 1'b0), 1'b1);
        tick();
        for (int i = 0; i < 3000; i++) begin
            if (issued >= 8 && exp_mem.size() == 0 && exp_ack.size() == 0)
                break;
            for (int c = 0; c < NC; c++) begin
                if (c_ack[c] && issued < 8) begin
                    put(mk(c, 1'b0, AW'(32'h100 * (c + 1) + issued), 16'h0,
                           DW'(32'h0C00 + issued), 1 + issued % 3, 1'b0), 1'b1);
                    issued++;
                end
            end
            tick();
        end
        wait_done();
        chk("fair_mem_reqs", 64'(nmem - n0), 64'(8));

        // Client 1 overwrites its pending request while client 0 is busy.
        n0 = nmem;
        put(mk(0, 1'b0, 22'h00321, 16'h0, 16'hC0DE, 10, 1'b1), 1'b1);
        tick();
        tick();
        tick();
        put(mk(1, 1'b0, 22'h00010, 16'h0, 16'h0BAD, 2, 1'b0), 1'b0);
        tick();
        put(mk(1, 1'b0, 22'h00020, 16'h0, 16'h600D, 2, 1'b0), 1'b1);
        tick();
        wait_done();
        chk("overwrite_mem_reqs", 64'(nmem - n0), 64'(2));

        // Write that is never acked, then a normal read by client 1.
        do_reset();
        chk("timeout_err_after_reset", 64'(timeout_err), 64'(0));
        put(mk(0, 1'b1, 22'h3FFFFF, 16'h5A5A, 16'h0, -1, 1'b1), 1'b1);
        tick();
        wait_done();
        chk("timeout_err_set", 64'(timeout_err), 64'(1));
        put(mk(1, 1'b0, 22'h0ABCD, 16'h0, 16'h1234, 4, 1'b1), 1'b1);
        tick();
        wait_done();
        chk("post_timeout_read", 64'(c_data_read[DW +: DW]), 64'(16'h1234));
        chk("timeout_err_sticky", 64'(timeout_err), 64'(1));

        // Asynchronous reset while waiting on the controller.
        put(mk(0, 1'b0, 22'h00777, 16'h0, 16'h7777, -1, 1'b1), 1'b1);
        tick();
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n0 = nmem;
        put(mk(1, 1'b0, 22'h00999, 16'h0, 16'h9999, 3, 1'b1), 1'b1);
        tick();
        wait_done();
        repeat (20) tick();
        chk("post_reset_mem_reqs", 64'(nmem - n0), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench did not complete");
    end

endmodule
